vector_decode_stage: RTL
========================

# vector_decode_stage

Parametrised decode stage for the vector ASIP, generalising the fixed 4-lane, 2-position decode unit. It holds the pixel and multiplier vector register files, decodes each 32-bit instruction into ALU/writeback controls, and registers operands and controls behind a valid/ready handshake, so the execute stage can stall it. It also owns the loop sequencer (i, j, n) and the write-only-memory (WOM) address generator.

## Interface
- LANES, default 4: vector lanes per register.
- BANKS, default 2: register positions per file; BANK_W = max(1, clog2(BANKS)).
- DATA_W, default 32: lane width.
- ROWS, COLS, default 16, 16: i/j iteration space; CNT_W = 32.
- WOM_DEPTH, default 256: WOM address wrap point.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- in_valid, in_ready  in/out  1  instruction handshake. in_ready = !out_valid || out_ready.
- instruction  in  32  [31:28] opcode, [27] src bank, [26] dst bank, [15:0] imm.
- we_pxl, wr_pos_pxl  in  1, BANK_W  pixel RF write enable and bank.
- wdp  in  LANES*DATA_W  pixel write data, lane 0 in the LSBs.
- we_mul, wr_mul_pos_in, wdm  in  1, BANK_W, LANES*DATA_W  multiplier RF write port.
- out_valid, out_ready  out/in  1  decoded-bundle handshake.
- alu_func, wr_pxl, wr_pos, wr_mul_reg, wr_mul_pos_out, wr_wom, illegal  out  1  controls.
- pix_out  out  LANES*DATA_W  pixel RF src-bank vector.
- cte_out  out  LANES*DATA_W  imm sign-extended, replicated per lane.
- mul_out  out  BANKS*LANES*DATA_W  all multiplier banks, bank 0 in the LSBs.
- i, j, n, wom_addr  out  CNT_W  sequencer state.
- loop_done  out  1  one-cycle pulse.

## Operation
- Opcodes (vasip_pkg): NOP=0000, SUMFV=0011, MULFV=0100, STWOM=0101, LOOP=0110. Any other opcode is decoded as NOP with illegal=1.
- Register files: written on clk when the enable is set. Bank indexes at or above BANKS are ignored.
- Capture: when in_valid && in_ready, the decode register loads the controls and operands and out_valid is set. The register holds unchanged while out_valid && !out_ready.
- Write bypass: if the RF write port hits the src bank in the capture cycle, pix_out/mul_out capture wdp/wdm, not the old contents.
- SUMFV: alu_func=0, wr_pxl=1, wr_pos=dst.
- MULFV: alu_func=1, wr_mul_reg=1, wr_mul_pos_out=dst.
- STWOM: wr_wom=1. wom_addr shows the current address.
- LOOP: all write controls are 0.
- Sequencer: updates only on the output handshake (out_valid && out_ready) of the instruction concerned.
  - SUMFV/MULFV: j+1. At COLS-1, j wraps to 0 and i+1. At ROWS-1, i wraps to 0. If n≠0, n−1; when n goes 1→0, loop_done pulses in the next cycle.
  - LOOP: n = imm (zero-extended), i = j = 0. This overrides any running loop.
  - STWOM: wom_addr+1, wrapping from WOM_DEPTH-1 to 0.

## Timing
- Reset values: every output is 0, except in_ready=1. Both RFs are cleared, and any in-flight instruction is dropped.
- Latency: one cycle from capture to out_valid. Throughput is one instruction per cycle while out_ready=1.
- i/j/n/wom_addr change one cycle after the output handshake.
- An instruction captured in the same cycle as that handshake sees the pre-update values in its bundle; counters are outputs, not part of the bundle.
- Reset asserted mid-stall clears everything at once; no handshake completes.

## Structure
- vasip_pkg: opcode enum, instruction field positions, and the decoded-control struct.
- Sub-module vec_regfile (BANKS, LANES, DATA_W), instantiated twice: one write port, one indexed read port, and a flattened all-banks output.

## Test plan
- Reset mid-stall: assert rst while out_valid=1, out_ready=0 → all outputs 0 and in_ready=1 at once; after release, the first capture produces a fresh bundle.
- RF write/read: write bank0 = {15,16,17,18} and bank1 = {150,160,170,180} to both files, then MULFV src=1 dst=1 → next cycle pix_out = {150,160,170,180}, mul_out = all 8 values, alu_func=1, wr_mul_reg=1, wr_mul_pos_out=1.
- Bypass: write bank0 = {1,2,3,4} in the same cycle SUMFV src=0 is captured → pix_out = {1,2,3,4}, wr_pxl=1, alu_func=0.
- Stall: hold out_ready=0 for 3 cycles with in_valid=1 → bundle stable, in_ready=0, counters unchanged; on release, exactly one handshake occurs.
- Loop: LOOP imm=3, then 3 SUMFV accepted → n goes 3, 2, 1, 0 with a single loop_done pulse. With COLS=2, i=1 and j=1 at the end.
- Wrap and illegal: WOM_DEPTH=4, 5× STWOM → wom_addr 0, 1, 2, 3, 0, 1. Opcode 1111 → illegal=1, all write controls 0, counters unchanged.

Source files
------------

// File: rtl/vasip_pkg.sv
// Shared types for the vector ASIP decode stage: opcodes, instruction
// field positions, the decoded-control bundle and the decoder function.
package vasip_pkg;

    typedef enum logic [3:0] {
        OP_NOP   = 4'b0000,
        OP_SUMFV = 4'b0011,
        OP_MULFV = 4'b0100,
        OP_STWOM = 4'b0101,
        OP_LOOP  = 4'b0110
    } opcode_e;

    localparam int OPC_HI  = 31;
    localparam int OPC_LO  = 28;
    localparam int SRC_BIT = 27;
    localparam int DST_BIT = 26;
    localparam int IMM_W   = 16;
    localparam int CNT_W   = 32;

    // Datapath controls plus the sequencer action the bundle will
    // trigger when it leaves the stage.
    typedef struct packed {
        logic             alu_func;
        logic             wr_pxl;
        logic             wr_pos;
        logic             wr_mul_reg;
        logic             wr_mul_pos;
        logic             wr_wom;
        logic             illegal;
        logic             seq_step;
        logic             seq_loop;
        logic             wom_step;
        logic [IMM_W-1:0] imm;
    } ctrl_t;

    function automatic ctrl_t decode(
        input logic [3:0]       opc,
        input logic             dst,
        input logic [IMM_W-1:0] imm
    );
        ctrl_t c;
        c     = '0;
        c.imm = imm;
        unique case (1'b1)
            (opc == OP_NOP): ;
            (opc == OP_SUMFV): begin
                c.wr_pxl   = 1'b1;
                c.wr_pos   = dst;
                c.seq_step = 1'b1;
            end
            (opc == OP_MULFV): begin
                c.alu_func   = 1'b1;
                c.wr_mul_reg = 1'b1;
                c.wr_mul_pos = dst;
                c.seq_step   = 1'b1;
            end
            (opc == OP_STWOM): begin
                c.wr_wom   = 1'b1;
                c.wom_step = 1'b1;
            end
            (opc == OP_LOOP): c.seq_loop = 1'b1;
            default: c.illegal = 1'b1;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/vector_decode_stage_if.sv
// Instruction-in / bundle-out handshake of the decode stage.
// slave: the decode stage; master: fetch + execute side.
interface vector_decode_stage_if #(
    parameter int LANES  = 4,
    parameter int BANKS  = 2,
    parameter int DATA_W = 32
);
    localparam int VEC_W = LANES * DATA_W;

    logic                   in_valid;
    logic                   in_ready;
    logic [31:0]            instruction;
    logic                   out_valid;
    logic                   out_ready;
    logic                   alu_func;
    logic                   wr_pxl;
    logic                   wr_pos;
    logic                   wr_mul_reg;
    logic                   wr_mul_pos_out;
    logic                   wr_wom;
    logic                   illegal;
    logic [VEC_W-1:0]       pix_out;
    logic [VEC_W-1:0]       cte_out;
    logic [BANKS*VEC_W-1:0] mul_out;

    modport slave (
        input  in_valid, instruction, out_ready,
        output in_ready, out_valid, alu_func, wr_pxl, wr_pos,
        output wr_mul_reg, wr_mul_pos_out, wr_wom, illegal,
        output pix_out, cte_out, mul_out
    );

    modport master (
        output in_valid, instruction, out_ready,
        input  in_ready, out_valid, alu_func, wr_pxl, wr_pos,
        input  wr_mul_reg, wr_mul_pos_out, wr_wom, illegal,
        input  pix_out, cte_out, mul_out
    );

endinterface

// File: rtl/vec_regfile.sv
// Banked vector register file: one write port, one indexed read port and
// a flattened all-banks view. Reads are write-first (same-cycle forward).
module vec_regfile #(
    parameter  int BANKS  = 2,
    parameter  int LANES  = 4,
    parameter  int DATA_W = 32,
    localparam int BANK_W = (BANKS > 1) ? $clog2(BANKS) : 1,
    localparam int VEC_W  = LANES * DATA_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   we,
    input  logic [BANK_W-1:0]      wr_idx,
    input  logic [VEC_W-1:0]       wdata,
    input  logic [BANK_W-1:0]      rd_idx,
    output logic [VEC_W-1:0]       rd_data,
    output logic [BANKS*VEC_W-1:0] all_data
);
    logic [BANKS-1:0][VEC_W-1:0] mem;
    logic [BANKS-1:0][VEC_W-1:0] fwd;
    logic                        wr_hit;

    // Out-of-range banks are silently dropped.
    assign wr_hit = we && (int'(wr_idx) < BANKS);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem <= '0;
        end else if (wr_hit) begin
            mem[wr_idx] <= wdata;
        end
    end

    always_comb begin
        fwd = mem;
        if (wr_hit) fwd[wr_idx] = wdata;
    end

    assign all_data = fwd;

    always_comb begin
        rd_data = '0;
        if (int'(rd_idx) < BANKS) rd_data = fwd[rd_idx];
    end

endmodule

// File: rtl/vector_decode_stage.sv
// Decode stage: RFs, decoder, registered bundle behind valid/ready, plus
// i/j/n loop sequencer and WOM address generator stepped on bundle exit.
module vector_decode_stage
    import vasip_pkg::*;
#(
    parameter  int LANES     = 4,
    parameter  int BANKS     = 2,
    parameter  int DATA_W    = 32,
    parameter  int ROWS      = 16,
    parameter  int COLS      = 16,
    parameter  int WOM_DEPTH = 256,
    localparam int BANK_W    = (BANKS > 1) ? $clog2(BANKS) : 1,
    localparam int VEC_W     = LANES * DATA_W
) (
    input  logic                clk,
    input  logic                rst,
    vector_decode_stage_if.slave bus,
    input  logic                we_pxl,
    input  logic [BANK_W-1:0]   wr_pos_pxl,
    input  logic [VEC_W-1:0]    wdp,
    input  logic                we_mul,
    input  logic [BANK_W-1:0]   wr_mul_pos_in,
    input  logic [VEC_W-1:0]    wdm,
    output logic [CNT_W-1:0]    i,
    output logic [CNT_W-1:0]    j,
    output logic [CNT_W-1:0]    n,
    output logic [CNT_W-1:0]    wom_addr,
    output logic                loop_done
);
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    ctrl_t                  dec;
    ctrl_t                  ctrl_q;
    logic                   valid_q;
    logic                   cap;
    logic                   fire;
    logic [BANK_W-1:0]      src_idx;
    logic [VEC_W-1:0]       pix_rd;
    logic [VEC_W-1:0]       pix_q;
    logic [VEC_W-1:0]       mul_rd_unused;
    logic [BANKS*VEC_W-1:0] pix_all_unused;
    logic [BANKS*VEC_W-1:0] mul_all;
    logic [BANKS*VEC_W-1:0] mul_q;
    logic [DATA_W-1:0]      cte_lane;
    logic                   unused_instr;

    assign dec = decode(bus.instruction[OPC_HI:OPC_LO],
                        bus.instruction[DST_BIT],
                        bus.instruction[IMM_W-1:0]);
    assign src_idx      = BANK_W'(bus.instruction[SRC_BIT]);
    assign unused_instr = ^bus.instruction[DST_BIT-1:IMM_W];

    assign bus.in_ready = !valid_q || bus.out_ready;
    assign cap          = bus.in_valid && bus.in_ready;
    assign fire         = valid_q && bus.out_ready;

    vec_regfile #(
        .BANKS(BANKS), .LANES(LANES), .DATA_W(DATA_W)
    ) u_pxl_rf (
        .clk(clk), .rst(rst),
        .we(we_pxl), .wr_idx(wr_pos_pxl), .wdata(wdp),
        .rd_idx(src_idx), .rd_data(pix_rd),
        .all_data(pix_all_unused)
    );

    vec_regfile #(
        .BANKS(BANKS), .LANES(LANES), .DATA_W(DATA_W)
    ) u_mul_rf (
        .clk(clk), .rst(rst),
        .we(we_mul), .wr_idx(wr_mul_pos_in), .wdata(wdm),
        .rd_idx(src_idx), .rd_data(mul_rd_unused),
        .all_data(mul_all)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            pix_q   <= '0;
            mul_q   <= '0;
        end else begin
            if (bus.in_ready) valid_q <= bus.in_valid;
            if (cap) begin
                ctrl_q <= dec;
                pix_q  <= pix_rd;
                mul_q  <= mul_all;
            end
        end
    end

    // Counters move only when the held bundle is consumed, so a stalled
    // instruction never advances the loop twice.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            i         <= '0;
            j         <= '0;
            n         <= '0;
            wom_addr  <= '0;
            loop_done <= 1'b0;
        end else begin
            loop_done <= 1'b0;
            if (fire) begin
                unique case (1'b1)
                    ctrl_q.seq_step: begin
                        if (j == CNT_W'(COLS - 1)) begin
                            j <= '0;
                            i <= (i == CNT_W'(ROWS - 1)) ? '0 : i + ONE;
                        end else begin
                            j <= j + ONE;
                        end
                        if (n != '0) begin
                            n         <= n - ONE;
                            loop_done <= (n == ONE);
                        end
                    end
                    ctrl_q.seq_loop: begin
                        n <= CNT_W'(ctrl_q.imm);
                        i <= '0;
                        j <= '0;
                    end
                    ctrl_q.wom_step: begin
                        wom_addr <= (wom_addr == CNT_W'(WOM_DEPTH - 1))
                                    ? '0 : wom_addr + ONE;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign cte_lane = DATA_W'($signed(ctrl_q.imm));

    assign bus.out_valid      = valid_q;
    assign bus.alu_func       = ctrl_q.alu_func;
    assign bus.wr_pxl         = ctrl_q.wr_pxl;
    assign bus.wr_pos         = ctrl_q.wr_pos;
    assign bus.wr_mul_reg     = ctrl_q.wr_mul_reg;
    assign bus.wr_mul_pos_out = ctrl_q.wr_mul_pos;
    assign bus.wr_wom         = ctrl_q.wr_wom;
    assign bus.illegal        = ctrl_q.illegal;
    assign bus.pix_out        = pix_q;
    assign bus.cte_out        = {LANES{cte_lane}};
    assign bus.mul_out        = mul_q;

endmodule
